// File: rtl/lvl_trg_pkg.sv
// lvl_trg_pkg: detector state encoding and edge-select constants for lvl_trg
package lvl_trg_pkg;
  typedef enum logic [1:0] {DISARMED, ARMED, HOLDOFF} state_t;
  localparam logic EDG_POS = 1'b0;
  localparam logic EDG_NEG = 1'b1;
endpackage

// File: rtl/lvl_trg_if.sv
// axi4_stream_if: DN-lane AXI4-Stream bundle with master/slave views
interface axi4_stream_if #(
  parameter int  DN = 1,
  parameter type DT = logic signed [13:0]
);
  DT [DN-1:0] TDATA;
  logic TLAST;
  logic TVALID;
  logic TREADY;
  modport master (output TDATA, TLAST, TVALID, input TREADY);
  modport slave (input TDATA, TLAST, TVALID, output TREADY);
endinterface

// File: rtl/lvl_trg_reg.sv
// axi4_stream_reg: one-stage AXI4-Stream register slice, 1-cycle latency, full throughput
module axi4_stream_reg #(
  parameter int  DN = 1,
  parameter type DT = logic signed [13:0]
) (
  input  logic           clk,
  input  logic           rstn,
  axi4_stream_if.slave   sti,
  axi4_stream_if.master  sto
);
  assign sti.TREADY = ~sto.TVALID | sto.TREADY;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sto.TVALID <= 1'b0;
      sto.TDATA  <= '0;
      sto.TLAST  <= 1'b0;
    end else if (sti.TVALID && sti.TREADY) begin
      sto.TVALID <= 1'b1;
      sto.TDATA  <= sti.TDATA;
      sto.TLAST  <= sti.TLAST;
    end else if (sto.TREADY) begin
      sto.TVALID <= 1'b0;
    end
endmodule

// File: rtl/lvl_trg.sv
// lvl_trg: hysteresis level/edge trigger on a registered sample stream; trg marks the
// cycle the firing sample first shows up on sto.
module lvl_trg
  import lvl_trg_pkg::*;
#(
  parameter int  DN = 1,
  parameter type DT = logic signed [13:0],
  parameter int  CW = 32
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           ctl_rst,
  input  logic           cfg_edg,
  input  DT              cfg_pos,
  input  DT              cfg_neg,
  input  logic [CW-1:0]  cfg_hld,
  output logic           sts_arm,
  output logic [CW-1:0]  sts_cnt,
  output logic           trg,
  axi4_stream_if.slave   sti,
  axi4_stream_if.master  sto
);
  if (DN != 1) begin : g_dn_chk
    $error("lvl_trg supports DN=1 only");
  end
  state_t        state;
  logic [CW-1:0] hld;
  logic          xfer, arm_c, fire_c;
  DT             s;
  axi4_stream_reg #(.DN(DN), .DT(DT)) u_reg (.clk(clk), .rstn(rstn), .sti(sti), .sto(sto));
  assign xfer    = sti.TVALID & sti.TREADY;
  assign s       = sti.TDATA[0];
  assign sts_arm = state == ARMED;
  always_comb begin
    arm_c  = cfg_edg == EDG_POS ? s <= cfg_neg : s >= cfg_pos;
    fire_c = cfg_edg == EDG_POS ? s >= cfg_pos : s <= cfg_neg;
  end
  // firing registers trg alongside the slice load, so both appear in the same cycle
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state   <= DISARMED;
      hld     <= '0;
      trg     <= 1'b0;
      sts_cnt <= '0;
    end else begin
      trg <= 1'b0;
      if (ctl_rst) begin
        state <= DISARMED;
        hld   <= '0;
      end else begin
        case (state)
          DISARMED: if (xfer && arm_c) state <= ARMED;
          ARMED: if (xfer && fire_c) begin
            state   <= HOLDOFF;
            hld     <= cfg_hld;
            trg     <= 1'b1;
            sts_cnt <= sts_cnt + 1'b1;
          end
          HOLDOFF: if (hld == '0) state <= DISARMED; else hld <= hld - 1'b1;
          default: state <= DISARMED;
        endcase
      end
    end
endmodule

// File: tb/tb_lvl_trg.sv
// tb_lvl_trg: table-driven vectors plus hand-written sequences for lvl_trg
module tb_lvl_trg;
  typedef logic signed [13:0] dt_t;
  typedef struct {
    logic cr;
    logic vld;
    logic edg;
    dt_t  s;
    logic e_vld;
    logic e_trg;
    logic e_arm;
  } vec_t;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ctl_rst = 1'b0;
  logic        cfg_edg = 1'b0;
  dt_t         cfg_pos = 14'sd4;
  dt_t         cfg_neg = -14'sd4;
  logic [31:0] cfg_hld = '0;
  logic        sts_arm, trg;
  logic [31:0] sts_cnt;
  logic [31:0] e_cnt = '0;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        v[$];
  axi4_stream_if #(.DN(1), .DT(dt_t)) sti ();
  axi4_stream_if #(.DN(1), .DT(dt_t)) sto ();
  lvl_trg #(.DN(1), .DT(dt_t), .CW(32)) dut (
    .clk(clk), .rstn(rstn), .ctl_rst(ctl_rst), .cfg_edg(cfg_edg), .cfg_pos(cfg_pos),
    .cfg_neg(cfg_neg), .cfg_hld(cfg_hld), .sts_arm(sts_arm), .sts_cnt(sts_cnt), .trg(trg),
    .sti(sti), .sto(sto)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic void add(input logic cr, vld, edg, input dt_t s, input logic ev, et, ea);
    v.push_back('{cr, vld, edg, s, ev, et, ea});
  endfunction
  task automatic clr();
    ctl_rst = 1'b1;
    sti.TVALID = 1'b0;
    @(posedge clk); #1;
    ctl_rst = 1'b0;
  endtask
  task automatic square(input logic [31:0] h, input int exp_n, input int exp_gap);
    int n, last, gap;
    n = 0; last = -100; gap = 1000;
    cfg_hld = h;
    cfg_edg = 1'b0;
    clr();
    for (int t = 0; t < 32; t++) begin
      sti.TVALID = 1'b1;
      sti.TDATA[0] = (t % 4 < 2) ? -14'sd8 : 14'sd8;
      @(posedge clk); #1;
      if (trg) begin
        if (n > 0 && t - last < gap) gap = t - last;
        last = t;
        n++;
      end
    end
    sti.TVALID = 1'b0;
    e_cnt += 32'(exp_n);
    chk($sformatf("sq%0d.pulses", h), n, exp_n);
    chk($sformatf("sq%0d.gap", h), gap, exp_gap);
    chk($sformatf("sq%0d.cnt", h), sts_cnt, e_cnt);
  endtask
  task automatic rnd_ramp();
    int idx, got, ntrg, bad_rdy, bad_trg, cyc;
    logic xf, ox;
    dt_t od;
    idx = 0; got = 0; ntrg = 0; bad_rdy = 0; bad_trg = 0; cyc = 0;
    xf = 1'b0; ox = 1'b0; od = '0;
    cfg_hld = '0;
    cfg_edg = 1'b0;
    clr();
    while (got < 17 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (xf) idx++;
      if (ox) begin
        chk($sformatf("rnd.data%0d", got), od, 64'(got - 8));
        got++;
      end
      if (trg) begin
        ntrg++;
        if (!(sto.TVALID && sto.TDATA[0] == 14'sd4)) bad_trg++;
      end
      if (!(sti.TVALID && !xf)) begin
        sti.TVALID = (idx < 17) && ($urandom_range(0, 2) != 0);
        sti.TDATA[0] = dt_t'(idx - 8);
      end
      sto.TREADY = $urandom_range(0, 1) == 1;
      #1;
      xf = sti.TVALID && sti.TREADY;
      ox = sto.TVALID && sto.TREADY;
      od = sto.TDATA[0];
      if (sto.TVALID && !sto.TREADY && sti.TREADY) bad_rdy++;
    end
    sti.TVALID = 1'b0;
    sto.TREADY = 1'b1;
    e_cnt++;
    chk("rnd.received", got, 17);
    chk("rnd.trg_count", ntrg, 1);
    chk("rnd.trg_align", bad_trg, 0);
    chk("rnd.ready_rule", bad_rdy, 0);
    chk("rnd.cnt", sts_cnt, e_cnt);
  endtask
  initial begin
    sti.TVALID = 1'b0;
    sti.TDATA[0] = '0;
    sti.TLAST = 1'b0;
    sto.TREADY = 1'b1;
    for (int i = -8; i <= 8; i++) add(1'b0, 1'b1, 1'b0, dt_t'(i), 1'b1, i == 4, i < 4);
    add(1'b1, 1'b0, 1'b0, 14'sd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 14'sd0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 14'sd5, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 14'sd3, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 14'sd5, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, -14'sd5, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 14'sd5, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 14'sd0, 1'b0, 1'b0, 1'b0);
    for (int i = 8; i >= -8; i--) add(1'b0, 1'b1, 1'b1, dt_t'(i), 1'b1, i == -4, i > -4);
    add(1'b1, 1'b0, 1'b0, 14'sd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, -14'sd8, 1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 14'sd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 14'sd8, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, -14'sd8, 1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 14'sd8, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 14'sd8, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.vld", sto.TVALID, 0);
    chk("rst.data", sto.TDATA[0], 0);
    chk("rst.last", sto.TLAST, 0);
    chk("rst.trg", trg, 0);
    chk("rst.cnt", sts_cnt, 0);
    chk("rst.arm", sts_arm, 0);
    rstn = 1'b1;
    foreach (v[k]) begin
      ctl_rst = v[k].cr;
      cfg_edg = v[k].edg;
      sti.TVALID = v[k].vld;
      sti.TDATA[0] = v[k].s;
      sti.TLAST = (k % 5) == 0;
      @(posedge clk); #1;
      if (v[k].e_trg) e_cnt++;
      chk($sformatf("v%0d.vld", k), sto.TVALID, v[k].e_vld);
      if (v[k].e_vld) begin
        chk($sformatf("v%0d.data", k), sto.TDATA[0], v[k].s);
        chk($sformatf("v%0d.last", k), sto.TLAST, (k % 5) == 0);
      end
      chk($sformatf("v%0d.trg", k), trg, v[k].e_trg);
      chk($sformatf("v%0d.arm", k), sts_arm, v[k].e_arm);
      chk($sformatf("v%0d.cnt", k), sts_cnt, e_cnt);
    end
    ctl_rst = 1'b0;
    sti.TVALID = 1'b0;
    sti.TLAST = 1'b0;
    square(32'd0, 8, 4);
    square(32'd10, 2, 16);
    rnd_ramp();
    cfg_hld = 32'd10;
    clr();
    sti.TVALID = 1'b1;
    sti.TDATA[0] = -14'sd8;
    @(posedge clk); #1;
    sti.TDATA[0] = 14'sd8;
    @(posedge clk); #1;
    e_cnt++;
    chk("hld.trg", trg, 1);
    chk("hld.cnt", sts_cnt, e_cnt);
    sti.TVALID = 1'b0;
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("arst.vld", sto.TVALID, 0);
    chk("arst.data", sto.TDATA[0], 0);
    chk("arst.trg", trg, 0);
    chk("arst.cnt", sts_cnt, 0);
    chk("arst.arm", sts_arm, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    sti.TVALID = 1'b1;
    sti.TDATA[0] = -14'sd8;
    @(posedge clk); #1;
    sti.TVALID = 1'b0;
    chk("arst.rearm", sts_arm, 1);
    chk("arst.data2", sto.TDATA[0], -8);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lvl_trg.md
Name: lvl_trg

Overview:
- Level/edge trigger stage that sits directly upstream of the acquire block.
- Passes the ADC sample stream through a one-stage register slice, sti -> sto.
- Detects threshold crossings with hysteresis and emits a one-cycle trigger pulse aligned with the triggering sample on sto.
- The trigger output drives one bit of acquire's ctl_trg; sto drives acquire's sti.

Parameters:
DN, 1, stream lanes; only 1 supported, elaboration-time error otherwise
DT, logic signed [14-1:0], sample type
CW, 32, holdoff and trigger-counter width

Ports:
clk  input  1  clock; same net as sti/sto ACLK
rstn  input  1  reset, asynchronous, active-low
ctl_rst  input  1  synchronous soft reset of detector (FSM, holdoff counter)
cfg_edg  input  1  0 = rising edge, 1 = falling edge
cfg_pos  input  DT  upper threshold (signed)
cfg_neg  input  DT  lower threshold (signed)
cfg_hld  input  CW  holdoff length in clk cycles after a trigger
sts_arm  output  1  detector in ARMED state
sts_cnt  output  CW  number of triggers since reset, wraps
trg  output  1  trigger pulse
sti  axi4_stream_if slave  DN x DT  input samples (TDATA, TLAST, TVALID, TREADY)
sto  axi4_stream_if master  DN x DT  output samples

Behaviour:
- Reset (rstn=0, async): sto.TVALID=0, sto.TDATA=0, sto.TLAST=0, trg=0, sts_cnt=0, state=DISARMED, holdoff counter=0, sts_arm=0.
- Register slice:
  - sti.TREADY = ~sto.TVALID | sto.TREADY.
  - On an sti transfer, TDATA/TLAST load into sto and sto.TVALID=1.
  - Otherwise, on an sto transfer, sto.TVALID=0.
  - Latency 1 cycle; full throughput under continuous ready; no data loss or duplication under any VALID/READY pattern.
- Detector is evaluated only on sti transfers, using sample s=sti.TDATA and signed compares:
  - Rising: arm condition s <= cfg_neg; fire condition s >= cfg_pos.
  - Falling: arm condition s >= cfg_pos; fire condition s <= cfg_neg.
- FSM states DISARMED, ARMED, HOLDOFF:
  - DISARMED: arm condition on transfer -> ARMED.
  - ARMED: fire condition on transfer -> HOLDOFF, load counter with cfg_hld, set trg.
  - HOLDOFF: counter decrements every clk regardless of transfers; -> DISARMED in the cycle it reads 0. cfg_hld=0 therefore gives a single HOLDOFF cycle.
  - Arm and fire never happen on the same sample; arming takes effect from the next transfer.
  - Samples transferred during HOLDOFF are ignored by the detector.
- trg:
  - High for exactly one cycle: the cycle the firing sample first appears on sto (sto.TVALID=1 with that TDATA).
  - trg is independent of sto.TREADY; acquire samples it as a level.
- sts_cnt increments in the same cycle trg=1 and wraps 2^CW-1 -> 0.
- sts_arm = (state==ARMED).
- ctl_rst=1: next state DISARMED, counter 0, trg 0 from next cycle. A fire in the same cycle as ctl_rst is suppressed. Register slice and sts_cnt are unaffected.
- cfg_edg/cfg_pos/cfg_neg changes apply to the next transfer; state is not cleared.
- cfg_neg > cfg_pos is legal: conditions are applied exactly as defined, with no special casing.
- TLAST is passed through and does not affect the detector.

Decomposition:
- Package lvl_trg_pkg: state enum (DISARMED, ARMED, HOLDOFF) and edge constants EDG_POS=1'b0, EDG_NEG=1'b1.
- Sub-module axi4_stream_reg (generic DN/DT one-stage register slice): lvl_trg instantiates it and adds only the detector and the trg register.

Test Plan:
- Rising ramp -8..8, cfg_pos=4, cfg_neg=-4, cfg_hld=0, full ready -> sto data == input; one trg pulse coincident with sto.TDATA==4; sts_cnt=1.
- Noise: samples 0,5,3,5,-5,5, rising, pos=4, neg=-4 -> exactly one trg, aligned with the last 5; sts_arm goes high after -5.
- Falling ramp 8..-8, cfg_edg=1, pos=4, neg=-4 -> one trg aligned with sto.TDATA==-4.
- Square wave -8,-8,8,8 repeated 8 times, continuous valid:
  - cfg_hld=0 -> 8 pulses, 4 cycles apart; sts_cnt=8.
  - cfg_hld=10 -> pulses at least 12 cycles apart; sts_cnt matches the pulse count.
- Ramp -8..8 with vld_max=2/vld_rnd=2 and random drain ready -> data intact; sti.TREADY=0 whenever sto holds data and sto.TREADY=0; exactly one trg at sample 4.
- Reset cases:
  - Sample -8 (ARMED), then ctl_rst pulse, then 8 -> no trg, sts_arm=0.
  - rstn asserted mid-HOLDOFF -> all outputs at reset values immediately.
